// File: rtl/snoop_wb_bus_intf_pkg.sv
// rtl/snoop_wb_bus_intf_pkg.sv - message codes and helpers shared by the snoop write-back bus interface
package snoop_wb_bus_intf_pkg;

    localparam logic [3:0] NO_REQ    = 4'd0;
    localparam logic [3:0] C_WB      = 4'd1;
    localparam logic [3:0] C_FLUSH   = 4'd2;
    localparam logic [3:0] MEM_RESP  = 4'd3;
    localparam logic [3:0] EN_ACCESS = 4'd4;

    // Ceiling log2; used for counter widths.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/snoop_wb_bus_intf_line_serializer.sv
// rtl/snoop_wb_bus_intf_line_serializer.sv - line register and beat counter producing per-beat address/data
module line_serializer
    import snoop_wb_bus_intf_pkg::*;
#(
    parameter int CACHE_OFFSET_BITS = 2,
    parameter int BUS_OFFSET_BITS   = 1,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDRESS_WIDTH     = 32
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       load,
    input  logic                                       advance,
    input  logic [ADDRESS_WIDTH-1:0]                   line_address,
    input  logic [(DATA_WIDTH<<CACHE_OFFSET_BITS)-1:0] line_in,
    output logic [ADDRESS_WIDTH-1:0]                   base_address,
    output logic [ADDRESS_WIDTH-1:0]                   beat_address,
    output logic [(DATA_WIDTH<<BUS_OFFSET_BITS)-1:0]   beat_data,
    output logic                                       last_beat
);

    localparam int CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS;
    localparam int BUS_WIDTH   = DATA_WIDTH << BUS_OFFSET_BITS;
    localparam int BEATS       = 1 << (CACHE_OFFSET_BITS - BUS_OFFSET_BITS);
    localparam int BEAT_BITS   = (BEATS > 1) ? log2(BEATS) : 1;

    logic [CACHE_WIDTH-1:0]   line_q;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [BEAT_BITS-1:0]     beat;
    logic                     unused_offset;

    assign unused_offset = ^line_address[CACHE_OFFSET_BITS-1:0];

    // The beat counter wraps to 0 after the last beat so a resend starts at the line base.
    always_ff @(posedge clock) begin
        if (!reset) begin
            line_q <= '0;
            base_q <= '0;
            beat   <= '0;
        end else if (load) begin
            line_q <= line_in;
            base_q <= {line_address[ADDRESS_WIDTH-1:CACHE_OFFSET_BITS], {CACHE_OFFSET_BITS{1'b0}}};
            beat   <= '0;
        end else if (advance) begin
            beat <= last_beat ? '0 : beat + BEAT_BITS'(1);
        end
    end

    assign last_beat    = (beat == BEAT_BITS'(BEATS - 1));
    assign base_address = base_q;
    assign beat_address = base_q + (ADDRESS_WIDTH'(beat) << BUS_OFFSET_BITS);
    assign beat_data    = line_q[int'(beat)*BUS_WIDTH +: BUS_WIDTH];

endmodule

// File: rtl/snoop_wb_bus_intf.sv
// rtl/snoop_wb_bus_intf.sv - snooper write-back to shared-bus serializer; optional watchdog via SNOOP_WB_TIMEOUT_EN
module snoop_wb_bus_intf
    import snoop_wb_bus_intf_pkg::*;
#(
    parameter int CACHE_OFFSET_BITS = 2,
    parameter int BUS_OFFSET_BITS   = 1,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDRESS_WIDTH     = 32,
    parameter int MSG_BITS          = 4,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [MSG_BITS-1:0]                        snoop_msg,
    input  logic [ADDRESS_WIDTH-1:0]                   snoop_address,
    input  logic [(DATA_WIDTH<<CACHE_OFFSET_BITS)-1:0] snoop_data,
    output logic [MSG_BITS-1:0]                        intf_msg,
    output logic [ADDRESS_WIDTH-1:0]                   intf_address,
    output logic                                       bus_req,
    input  logic                                       bus_grant,
    output logic [MSG_BITS-1:0]                        bus_msg_out,
    output logic [ADDRESS_WIDTH-1:0]                   bus_address_out,
    output logic [(DATA_WIDTH<<BUS_OFFSET_BITS)-1:0]   bus_data_out,
    input  logic [MSG_BITS-1:0]                        bus_msg_in
`ifdef SNOOP_WB_TIMEOUT_EN
    ,
    output logic                                       wb_timeout
`endif
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REQ_BUS   = 3'd1;
    localparam logic [2:0] SEND      = 3'd2;
    localparam logic [2:0] WAIT_RESP = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] DRAIN     = 3'd5;
    localparam logic [2:0] EN_ACK    = 3'd6;

    localparam int BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS;

    logic [2:0]               state;
    logic [MSG_BITS-1:0]      msg_q;
    logic                     is_wb;
    logic                     load;
    logic                     advance;
    logic                     last_beat;
    logic [ADDRESS_WIDTH-1:0] base_address;
    logic [ADDRESS_WIDTH-1:0] beat_address;
    logic [BUS_WIDTH-1:0]     beat_data;

`ifdef SNOOP_WB_TIMEOUT_EN
    localparam int CNT_BITS = log2(TIMEOUT_CYCLES) + 1;
    logic [CNT_BITS-1:0] wait_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign is_wb   = (snoop_msg == MSG_BITS'(C_WB)) || (snoop_msg == MSG_BITS'(C_FLUSH));
    assign load    = (state == IDLE) && is_wb;
    assign advance = (state == SEND) && bus_grant;

    line_serializer #(
        .CACHE_OFFSET_BITS (CACHE_OFFSET_BITS),
        .BUS_OFFSET_BITS   (BUS_OFFSET_BITS),
        .DATA_WIDTH        (DATA_WIDTH),
        .ADDRESS_WIDTH     (ADDRESS_WIDTH)
    ) u_line_serializer (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .advance      (advance),
        .line_address (snoop_address),
        .line_in      (snoop_data),
        .base_address (base_address),
        .beat_address (beat_address),
        .beat_data    (beat_data),
        .last_beat    (last_beat)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            msg_q           <= MSG_BITS'(NO_REQ);
            bus_req         <= 1'b0;
            bus_msg_out     <= MSG_BITS'(NO_REQ);
            bus_address_out <= '0;
            bus_data_out    <= '0;
            intf_msg        <= MSG_BITS'(NO_REQ);
            intf_address    <= '0;
`ifdef SNOOP_WB_TIMEOUT_EN
            wait_cnt        <= '0;
            wb_timeout      <= 1'b0;
`endif
        end else begin
`ifdef SNOOP_WB_TIMEOUT_EN
            if (state != WAIT_RESP) wait_cnt <= '0;
`endif
            case (state)
                IDLE: begin
                    if (is_wb) begin
                        msg_q   <= snoop_msg;
                        bus_req <= 1'b1;
                        state   <= REQ_BUS;
                    end else if (snoop_msg == MSG_BITS'(EN_ACCESS)) begin
                        intf_msg <= MSG_BITS'(EN_ACCESS);
                        state    <= EN_ACK;
                    end
                end
                REQ_BUS: begin
                    if (bus_grant) state <= SEND;
                end
                SEND: begin
                    // A dropped grant stalls here with the previous beat still on the bus.
                    if (bus_grant) begin
                        bus_msg_out     <= msg_q;
                        bus_address_out <= beat_address;
                        bus_data_out    <= beat_data;
                        if (last_beat) state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus_msg_in == MSG_BITS'(MEM_RESP)) begin
                        bus_req      <= 1'b0;
                        bus_msg_out  <= MSG_BITS'(NO_REQ);
                        intf_msg     <= MSG_BITS'(MEM_RESP);
                        intf_address <= base_address;
                        state        <= ACK;
                    end
`ifdef SNOOP_WB_TIMEOUT_EN
                    else if (wait_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
                        wb_timeout <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_BITS'(1);
                    end
`endif
                end
                ACK: begin
                    intf_msg     <= MSG_BITS'(NO_REQ);
                    intf_address <= '0;
                    state        <= DRAIN;
                end
                DRAIN: begin
                    if (!is_wb) state <= IDLE;
                end
                EN_ACK: begin
                    intf_msg <= MSG_BITS'(NO_REQ);
                    if (snoop_msg != MSG_BITS'(EN_ACCESS)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_wb_bus_intf.sv
// tb/tb_snoop_wb_bus_intf.sv - directed self-checking bench for snoop_wb_bus_intf
module tb_snoop_wb_bus_intf;

    localparam logic [3:0] NO_REQ    = 4'd0;
    localparam logic [3:0] C_WB      = 4'd1;
    localparam logic [3:0] C_FLUSH   = 4'd2;
    localparam logic [3:0] MEM_RESP  = 4'd3;
    localparam logic [3:0] EN_ACCESS = 4'd4;
`ifdef SNOOP_WB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   snoop_msg = NO_REQ;
    logic [31:0]  snoop_address = '0;
    logic [127:0] snoop_data = '0;
    logic [3:0]   intf_msg;
    logic [31:0]  intf_address;
    logic         bus_req;
    logic         bus_grant = 1'b0;
    logic [3:0]   bus_msg_out;
    logic [31:0]  bus_address_out;
    logic [63:0]  bus_data_out;
    logic [3:0]   bus_msg_in = NO_REQ;
`ifdef SNOOP_WB_TIMEOUT_EN
    logic         wb_timeout;
`endif

    int vectors = 0;
    int miscompares = 0;

    snoop_wb_bus_intf #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock           (clock),
        .reset           (reset),
        .snoop_msg       (snoop_msg),
        .snoop_address   (snoop_address),
        .snoop_data      (snoop_data),
        .intf_msg        (intf_msg),
        .intf_address    (intf_address),
        .bus_req         (bus_req),
        .bus_grant       (bus_grant),
        .bus_msg_out     (bus_msg_out),
        .bus_address_out (bus_address_out),
        .bus_data_out    (bus_data_out),
        .bus_msg_in      (bus_msg_in)
`ifdef SNOOP_WB_TIMEOUT_EN
        ,
        .wb_timeout      (wb_timeout)
`endif
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step(2);
        vectors++; if (intf_msg !== NO_REQ) begin miscompares++; $display("FAIL rst_intf_msg got %h want %h", intf_msg, NO_REQ); end
        vectors++; if (bus_msg_out !== NO_REQ) begin miscompares++; $display("FAIL rst_bus_msg got %h want %h", bus_msg_out, NO_REQ); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rst_bus_req got %b want 0", bus_req); end
        vectors++; if (bus_address_out !== 32'h0 || intf_address !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h/%h want 0/0", bus_address_out, intf_address); end
        vectors++; if (bus_data_out !== 64'h0) begin miscompares++; $display("FAIL rst_data got %h want 0", bus_data_out); end
`ifdef SNOOP_WB_TIMEOUT_EN
        vectors++; if (wb_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got %b want 0", wb_timeout); end
`endif
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_c_wb;
        snoop_msg = C_WB; snoop_address = 32'h11223344;
        snoop_data = 128'h44444444_33333333_22222222_11111111;
        step(1);
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL wb_req got %b want 1", bus_req); end
        step(2);
        vectors++; if (bus_req !== 1'b1 || bus_msg_out !== NO_REQ) begin miscompares++; $display("FAIL wb_wait_grant got %b/%h want 1/%h", bus_req, bus_msg_out, NO_REQ); end
        bus_grant = 1'b1;
        step(2);
        vectors++; if (bus_msg_out !== C_WB) begin miscompares++; $display("FAIL wb_b0_msg got %h want %h", bus_msg_out, C_WB); end
        vectors++; if (bus_address_out !== 32'h11223344) begin miscompares++; $display("FAIL wb_b0_addr got %h want 11223344", bus_address_out); end
        vectors++; if (bus_data_out !== 64'h22222222_11111111) begin miscompares++; $display("FAIL wb_b0_data got %h want 2222222211111111", bus_data_out); end
        step(1);
        vectors++; if (bus_address_out !== 32'h11223346) begin miscompares++; $display("FAIL wb_b1_addr got %h want 11223346", bus_address_out); end
        vectors++; if (bus_data_out !== 64'h44444444_33333333) begin miscompares++; $display("FAIL wb_b1_data got %h want 4444444433333333", bus_data_out); end
        step(2);
        vectors++; if (bus_address_out !== 32'h11223346 || bus_msg_out !== C_WB || bus_req !== 1'b1) begin miscompares++; $display("FAIL wb_wait_hold got %h/%h/%b want 11223346/%h/1", bus_address_out, bus_msg_out, bus_req, C_WB); end
        vectors++; if (intf_msg !== NO_REQ) begin miscompares++; $display("FAIL wb_early_resp got %h want %h", intf_msg, NO_REQ); end
        bus_msg_in = MEM_RESP;
        step(1);
        vectors++; if (intf_msg !== MEM_RESP || intf_address !== 32'h11223344) begin miscompares++; $display("FAIL wb_ack got %h@%h want %h@11223344", intf_msg, intf_address, MEM_RESP); end
        vectors++; if (bus_req !== 1'b0 || bus_msg_out !== NO_REQ) begin miscompares++; $display("FAIL wb_release got %b/%h want 0/%h", bus_req, bus_msg_out, NO_REQ); end
        bus_msg_in = NO_REQ; bus_grant = 1'b0;
        step(1);
        vectors++; if (intf_msg !== NO_REQ) begin miscompares++; $display("FAIL wb_ack_len got %h want %h", intf_msg, NO_REQ); end
        step(2);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL wb_no_resend got %b want 0", bus_req); end
        snoop_msg = NO_REQ;
        step(1);
    endtask

    task automatic test_c_flush;
        snoop_msg = C_FLUSH; snoop_address = 32'h5555002E;
        snoop_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        bus_grant = 1'b1;
        step(1);
        snoop_address = 32'h0; snoop_data = '0;
        step(2);
        vectors++; if (bus_msg_out !== C_FLUSH) begin miscompares++; $display("FAIL fl_msg got %h want %h", bus_msg_out, C_FLUSH); end
        vectors++; if (bus_address_out !== 32'h5555002C || bus_data_out !== 64'hBBBBBBBB_AAAAAAAA) begin miscompares++; $display("FAIL fl_b0 got %h:%h want 5555002c:bbbbbbbbaaaaaaaa", bus_address_out, bus_data_out); end
        step(1);
        vectors++; if (bus_address_out !== 32'h5555002E || bus_data_out !== 64'hDDDDDDDD_CCCCCCCC) begin miscompares++; $display("FAIL fl_b1 got %h:%h want 5555002e:ddddddddcccccccc", bus_address_out, bus_data_out); end
        bus_msg_in = MEM_RESP;
        step(1);
        vectors++; if (intf_msg !== MEM_RESP || intf_address !== 32'h5555002C) begin miscompares++; $display("FAIL fl_ack got %h@%h want %h@5555002c", intf_msg, intf_address, MEM_RESP); end
        bus_msg_in = NO_REQ; bus_grant = 1'b0; snoop_msg = NO_REQ;
        step(2);
    endtask

    task automatic test_stall;
        snoop_msg = C_WB; snoop_address = 32'h00000100;
        snoop_data = 128'h0000000D_0000000C_0000000B_0000000A;
        bus_grant = 1'b1;
        step(3);
        vectors++; if (bus_address_out !== 32'h00000100) begin miscompares++; $display("FAIL st_b0 got %h want 00000100", bus_address_out); end
        bus_grant = 1'b0; bus_msg_in = MEM_RESP;
        step(1);
        vectors++; if (bus_address_out !== 32'h00000100 || bus_data_out !== 64'h0000000B_0000000A) begin miscompares++; $display("FAIL st_hold1 got %h:%h want 00000100:0000000b0000000a", bus_address_out, bus_data_out); end
        vectors++; if (intf_msg !== NO_REQ) begin miscompares++; $display("FAIL st_stray_resp got %h want %h", intf_msg, NO_REQ); end
        bus_msg_in = NO_REQ;
        step(1);
        vectors++; if (bus_address_out !== 32'h00000100) begin miscompares++; $display("FAIL st_hold2 got %h want 00000100", bus_address_out); end
        bus_grant = 1'b1;
        step(1);
        vectors++; if (bus_address_out !== 32'h00000102 || bus_data_out !== 64'h0000000D_0000000C) begin miscompares++; $display("FAIL st_b1 got %h:%h want 00000102:0000000d0000000c", bus_address_out, bus_data_out); end
        step(1);
        vectors++; if (bus_address_out !== 32'h00000102 || bus_req !== 1'b1) begin miscompares++; $display("FAIL st_no_repeat got %h/%b want 00000102/1", bus_address_out, bus_req); end
        bus_msg_in = MEM_RESP;
        step(1);
        vectors++; if (intf_msg !== MEM_RESP) begin miscompares++; $display("FAIL st_ack got %h want %h", intf_msg, MEM_RESP); end
        bus_msg_in = NO_REQ; bus_grant = 1'b0; snoop_msg = NO_REQ;
        step(2);
    endtask

    task automatic test_en_access;
        int hits;
        int req_seen;
        hits = 0; req_seen = 0;
        snoop_msg = EN_ACCESS;
        step(1);
        vectors++; if (intf_msg !== EN_ACCESS) begin miscompares++; $display("FAIL en_first got %h want %h", intf_msg, EN_ACCESS); end
        hits = 1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (intf_msg === EN_ACCESS) hits++;
            if (bus_req !== 1'b0) req_seen++;
        end
        vectors++; if (hits != 1) begin miscompares++; $display("FAIL en_count got %0d want 1", hits); end
        vectors++; if (req_seen != 0) begin miscompares++; $display("FAIL en_bus_req got %0d want 0", req_seen); end
        snoop_msg = NO_REQ;
        step(1);
    endtask

    task automatic test_reset_mid;
        snoop_msg = C_WB; snoop_address = 32'h00000300;
        snoop_data = 128'h1;
        bus_grant = 1'b1;
        step(3);
        reset = 1'b0; snoop_msg = NO_REQ;
        step(1);
        vectors++; if (bus_req !== 1'b0 || bus_msg_out !== NO_REQ) begin miscompares++; $display("FAIL rm_abort got %b/%h want 0/%h", bus_req, bus_msg_out, NO_REQ); end
        reset = 1'b1; bus_grant = 1'b0;
        step(1);
        snoop_msg = EN_ACCESS;
        step(1);
        vectors++; if (intf_msg !== EN_ACCESS) begin miscompares++; $display("FAIL rm_idle got %h want %h", intf_msg, EN_ACCESS); end
        snoop_msg = NO_REQ;
        step(2);
    endtask

`ifdef SNOOP_WB_TIMEOUT_EN
    task automatic test_timeout;
        snoop_msg = C_WB; snoop_address = 32'h00000200;
        snoop_data = 128'h0000000D_0000000C_0000000B_0000000A;
        bus_grant = 1'b1;
        step(4);
        step(7);
        vectors++; if (wb_timeout !== 1'b0) begin miscompares++; $display("FAIL to_early got %b want 0", wb_timeout); end
        step(1);
        vectors++; if (wb_timeout !== 1'b1) begin miscompares++; $display("FAIL to_flag got %b want 1", wb_timeout); end
        step(1);
        vectors++; if (bus_address_out !== 32'h00000200 || bus_req !== 1'b1) begin miscompares++; $display("FAIL to_resend0 got %h/%b want 00000200/1", bus_address_out, bus_req); end
        step(1);
        vectors++; if (bus_address_out !== 32'h00000202) begin miscompares++; $display("FAIL to_resend1 got %h want 00000202", bus_address_out); end
        bus_msg_in = MEM_RESP;
        step(1);
        vectors++; if (intf_msg !== MEM_RESP || wb_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %h/%b want %h/1", intf_msg, wb_timeout, MEM_RESP); end
        bus_msg_in = NO_REQ; bus_grant = 1'b0; snoop_msg = NO_REQ;
        step(2);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        test_reset();
        test_c_wb();
        test_c_flush();
        test_stall();
        test_en_access();
        test_reset_mid();
`ifdef SNOOP_WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
